// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: state encoding,
// frame geometry, the default bit period and the parity helper.
package uart_pkg;

  // Number of data bits carried in one frame.
  localparam int DATA_BITS = 8;

  // Bit period used when the instantiating level does not override it.
  localparam int DEFAULT_CLKS_PER_BIT = 16;

  // Transmitter states, 3-bit encoding.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Parity over the data bits: even parity is the plain XOR, odd inverts it.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data,
                                      input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer for the UART transmitter. A load strobe restarts the
// period at CLKS_PER_BIT-1; the count then runs down and parks at zero.
// bit_end is high whenever the count is zero, i.e. on the last clock of a bit.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  // Reload on request, otherwise count down and hold once zero is reached.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign bit_end = (count == '0);

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmitter: start bit, 8 data bits LSB first, parity bit, stop bit.
// Optional build macro UART_TX_TWO_STOP_EN stretches the stop phase to two
// bit periods; without it a single stop bit is sent.
// The serial line, busy flag and done pulse all come straight from flops.
module uart_tx_fsm #(
  parameter int CLKS_PER_BIT = uart_pkg::DEFAULT_CLKS_PER_BIT,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  import uart_pkg::*;

  tx_state_t            state, state_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [2:0]           bit_idx, idx_next;
  logic                 par_reg, par_next;
  logic                 tx_next, busy_next, done_next;
  logic                 baud_load;
  logic                 bit_end;
`ifdef UART_TX_TWO_STOP_EN
  logic                 stop_second, stop_second_next;
`endif

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clock  (clock),
    .reset  (reset),
    .load   (baud_load),
    .bit_end(bit_end)
  );

  // State, datapath and output registers; reset drops the frame and idles the line.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_idx   <= '0;
      par_reg   <= 1'b0;
      tx        <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop_second <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      bit_idx   <= idx_next;
      par_reg   <= par_next;
      tx        <= tx_next;
      tx_busy   <= busy_next;
      tx_done   <= done_next;
`ifdef UART_TX_TWO_STOP_EN
      stop_second <= stop_second_next;
`endif
    end
  end

  // Next-state logic; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_next = state;
    shift_next = shift_reg;
    idx_next   = bit_idx;
    par_next   = par_reg;
    done_next  = 1'b0;
    baud_load  = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
    stop_second_next = stop_second;
`endif

    case (state)
      IDLE: begin
        if (tx_start) begin
          state_next = START;
          shift_next = tx_data;
          par_next   = parity_bit(tx_data, PARITY_ODD);
          baud_load  = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          idx_next   = 3'd0;
          baud_load  = 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_next = {1'b0, shift_reg[DATA_BITS-1:1]};
          idx_next   = bit_idx + 3'd1;
          baud_load  = 1'b1;
          if (bit_idx == 3'd7) begin
            state_next = PARITY;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_next = STOP;
          baud_load  = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
          stop_second_next = 1'b0;
`endif
        end
      end
      STOP: begin
        if (bit_end) begin
`ifdef UART_TX_TWO_STOP_EN
          if (!stop_second) begin
            stop_second_next = 1'b1;
            baud_load        = 1'b1;
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
`else
          state_next = IDLE;
          done_next  = 1'b1;
`endif
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = par_next;
      default: tx_next = 1'b1;
    endcase

    busy_next = (state_next != IDLE);
  end

endmodule
